operand_fetch: RTL and testbench

- Initiator side of the 16x32 register file: drives its two synchronous read ports and its single write port.
- Accepts decoded instructions (source regs Rn/Rm, optional destination Rd) from decode over a valid/ready handshake.
- Tracks pending destination writes in a 16-bit scoreboard, forwards same-cycle writeback data, and substitutes PC+8 for R15 reads.
- Presents resolved operands to execute over a second valid/ready handshake.

---
 rtl/operand_fetch.sv | 147 ++++++++++++++
 tb/tb_operand_fetch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch: drives the 16x32 regfile ports, scoreboards pending writes and resolves operands.
// Optional OPFETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module operand_fetch #(
    parameter int unsigned DW        = 32,
    parameter int unsigned PC_OFFSET = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [3:0]    req_rn,
    input  logic [3:0]    req_rm,
    input  logic [3:0]    req_rd,
    input  logic          req_has_rd,
    input  logic [DW-1:0] req_pc,
    input  logic          wb_en,
    input  logic [3:0]    wb_reg,
    input  logic [DW-1:0] wb_data,
    output logic [3:0]    rf_read_reg0,
    output logic [3:0]    rf_read_reg1,
    input  logic [DW-1:0] rf_read_data0,
    input  logic [DW-1:0] rf_read_data1,
    output logic          rf_write_en,
    output logic [3:0]    rf_write_reg,
    output logic [DW-1:0] rf_write_data,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic [3:0]    op_rd,
    output logic          op_has_rd
`ifdef OPFETCH_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {StIdle, StRead, StHold} state_t;

    state_t        r_state;
    logic [15:0]   r_sb;
    logic [3:0]    r_rn;
    logic [3:0]    r_rm;
    logic [3:0]    r_rd;
    logic          r_has_rd;
    logic [DW-1:0] r_pc8;
    logic          r_fwd_a;
    logic          r_fwd_b;
    logic [DW-1:0] r_wb_data;

    logic [15:0]   w_clr;
    logic [15:0]   w_set;
    logic [15:0]   w_sb_eff;
    logic          w_hazard;
    logic          w_accept;
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;

    assign rf_read_reg0  = req_rn;
    assign rf_read_reg1  = req_rm;
    assign rf_write_en   = wb_en;
    assign rf_write_reg  = wb_reg;
    assign rf_write_data = wb_data;

    // A bit cleared by this cycle's writeback no longer blocks issue.
    assign w_clr    = wb_en ? (16'h1 << wb_reg) : 16'h0;
    assign w_sb_eff = r_sb & ~w_clr;
    assign w_hazard = (w_sb_eff[req_rn] && (req_rn != 4'd15)) ||
                      (w_sb_eff[req_rm] && (req_rm != 4'd15)) ||
                      (req_has_rd && w_sb_eff[req_rd]);

    assign req_ready = reset && !w_hazard &&
                       ((r_state == StIdle) || ((r_state == StHold) && op_ready));
    assign w_accept  = req_valid && req_ready;
    assign w_set     = (w_accept && req_has_rd) ? (16'h1 << req_rd) : 16'h0;

    // Regfile returns the pre-write value, so a same-cycle writeback is forwarded.
    assign w_a = (r_rn == 4'd15) ? r_pc8 : (r_fwd_a ? r_wb_data : rf_read_data0);
    assign w_b = (r_rm == 4'd15) ? r_pc8 : (r_fwd_b ? r_wb_data : rf_read_data1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= StIdle;
            r_sb      <= 16'h0;
            r_rn      <= 4'd0;
            r_rm      <= 4'd0;
            r_rd      <= 4'd0;
            r_has_rd  <= 1'b0;
            r_pc8     <= '0;
            r_fwd_a   <= 1'b0;
            r_fwd_b   <= 1'b0;
            r_wb_data <= '0;
            op_valid  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            op_rd     <= 4'd0;
            op_has_rd <= 1'b0;
        end else begin
            r_sb <= w_sb_eff | w_set;
            if (w_accept) begin
                r_rn      <= req_rn;
                r_rm      <= req_rm;
                r_rd      <= req_rd;
                r_has_rd  <= req_has_rd;
                r_pc8     <= req_pc + DW'(PC_OFFSET);
                r_fwd_a   <= wb_en && (wb_reg == req_rn);
                r_fwd_b   <= wb_en && (wb_reg == req_rm);
                r_wb_data <= wb_data;
            end
            case (r_state)
                StIdle: begin
                    if (w_accept) r_state <= StRead;
                end
                StRead: begin
                    r_state   <= StHold;
                    op_valid  <= 1'b1;
                    op_a      <= w_a;
                    op_b      <= w_b;
                    op_rd     <= r_rd;
                    op_has_rd <= r_has_rd;
                end
                StHold: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        r_state  <= w_accept ? StRead : StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 32'd0;
        end else if (req_valid && w_hazard && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch with a behavioural 16x32 regfile model.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_rn;
    logic [3:0]  req_rm;
    logic [3:0]  req_rd;
    logic        req_has_rd;
    logic [31:0] req_pc;
    logic        wb_en;
    logic [3:0]  wb_reg;
    logic [31:0] wb_data;
    logic [3:0]  rf_read_reg0;
    logic [3:0]  rf_read_reg1;
    logic [31:0] rf_read_data0;
    logic [31:0] rf_read_data1;
    logic        rf_write_en;
    logic [3:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_rd;
    logic        op_has_rd;
`ifdef OPFETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks;
    int n_errors;

    logic [31:0] mem [16];

    operand_fetch #(
        .DW        (32),
        .PC_OFFSET (8)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_rn        (req_rn),
        .req_rm        (req_rm),
        .req_rd        (req_rd),
        .req_has_rd    (req_has_rd),
        .req_pc        (req_pc),
        .wb_en         (wb_en),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .rf_read_reg0  (rf_read_reg0),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_data0 (rf_read_data0),
        .rf_read_data1 (rf_read_data1),
        .rf_write_en   (rf_write_en),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_rd         (op_rd),
        .op_has_rd     (op_has_rd)
`ifdef OPFETCH_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read regfile: a same-cycle write is not visible to the read.
    always @(posedge clk) begin
        rf_read_data0 <= mem[rf_read_reg0];
        rf_read_data1 <= mem[rf_read_reg1];
        if (rf_write_en) mem[rf_write_reg] <= rf_write_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                           input logic [3:0] rd, input logic has_rd, input logic [31:0] pc);
        req_valid  = v;
        req_rn     = rn;
        req_rm     = rm;
        req_rd     = rd;
        req_has_rd = has_rd;
        req_pc     = pc;
    endtask

    task automatic set_wb(input logic en, input logic [3:0] r, input logic [31:0] d);
        wb_en   = en;
        wb_reg  = r;
        wb_data = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b0;
        op_ready = 1'b0;
        set_req(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 32'h0);
        set_wb(1'b0, 4'd0, 32'h0);

        // Reset state
        #2;
        req_valid = 1'b1;
        #1;
        check_eq("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_eq("rst_op_valid", {31'd0, op_valid}, 32'd0);
        check_eq("rst_op_a", op_a, 32'h0);
        req_valid = 1'b0;
        step();
        step();
        reset = 1'b1;

        // Preload R1..R4 through the write port (scoreboard stays clear)
        set_wb(1'b1, 4'd1, 32'h11); step();
        set_wb(1'b1, 4'd2, 32'h22); step();
        set_wb(1'b1, 4'd3, 32'h33); step();
        set_wb(1'b1, 4'd4, 32'h44); step();
        set_wb(1'b0, 4'd0, 32'h0);
        check_eq("preload_no_op", {31'd0, op_valid}, 32'd0);

        // Basic read: rn=1, rm=2
        set_req(1'b1, 4'd1, 4'd2, 4'd0, 1'b0, 32'h0);
        #1;
        check_eq("t1_ready_idle", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        check_eq("t1_valid_t1", {31'd0, op_valid}, 32'd0);
        step();
        check_eq("t1_valid_t2", {31'd0, op_valid}, 32'd1);
        check_eq("t1_op_a", op_a, 32'h11);
        check_eq("t1_op_b", op_b, 32'h22);
        check_eq("t1_ready_hold", {31'd0, req_ready}, 32'd0);
        op_ready = 1'b1;
        #1;
        check_eq("t1_ready_opready", {31'd0, req_ready}, 32'd1);
        step();
        op_ready = 1'b0;
        check_eq("t1_idle_valid", {31'd0, op_valid}, 32'd0);

        // RAW hazard on R3 resolved by same-cycle writeback forwarding
        set_req(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        check_eq("t2_op_rd", {28'd0, op_rd}, 32'd3);
        check_eq("t2_op_has_rd", {31'd0, op_has_rd}, 32'd1);
        op_ready = 1'b1;
        set_req(1'b1, 4'd3, 4'd2, 4'd0, 1'b0, 32'h0);
        #1;
        check_eq("t2_stall_hold", {31'd0, req_ready}, 32'd0);
        step();
        op_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_stall_idle", {31'd0, req_ready}, 32'd0);
            step();
        end
`ifdef OPFETCH_STALL_CNT_EN
        check_eq("t2_stall_cnt", stall_cnt, 32'd4);
`endif
        set_wb(1'b1, 4'd3, 32'hABCD);
        #1;
        check_eq("t2_ready_on_wb", {31'd0, req_ready}, 32'd1);
        step();
        set_wb(1'b0, 4'd0, 32'h0);
        req_valid = 1'b0;
        step();
        check_eq("t2_fwd_op_a", op_a, 32'hABCD);
        check_eq("t2_op_b", op_b, 32'h22);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;

        // R15 sources with sb[15] set: PC+8, no stall
        set_req(1'b1, 4'd1, 4'd2, 4'd15, 1'b1, 32'h0);
        step();
        req_valid = 1'b0;
        step();
        op_ready = 1'b1;
        set_req(1'b1, 4'd15, 4'd15, 4'd0, 1'b0, 32'h100);
        #1;
        check_eq("t3_r15_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        op_ready  = 1'b0;
        check_eq("t3_read_valid", {31'd0, op_valid}, 32'd0);
        step();
        check_eq("t3_op_a", op_a, 32'h108);
        check_eq("t3_op_b", op_b, 32'h108);

        // Backpressure: outputs hold for 5 cycles, pending req waits
        set_req(1'b1, 4'd1, 4'd2, 4'd5, 1'b1, 32'h200);
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_hold_valid", {31'd0, op_valid}, 32'd1);
            check_eq("t4_hold_a", op_a, 32'h108);
            check_eq("t4_hold_b", op_b, 32'h108);
            check_eq("t4_hold_rd", {28'd0, op_rd}, 32'd0);
            check_eq("t4_hold_ready", {31'd0, req_ready}, 32'd0);
            step();
        end
        op_ready = 1'b1;
        #1;
        check_eq("t4_ready_release", {31'd0, req_ready}, 32'd1);
        step();
        op_ready  = 1'b0;
        req_valid = 1'b0;
        step();
        check_eq("t4_op_a", op_a, 32'h11);
        check_eq("t4_op_rd", {28'd0, op_rd}, 32'd5);
        check_eq("t4_op_has_rd", {31'd0, op_has_rd}, 32'd1);
        op_ready = 1'b1;
        step();
        op_ready = 1'b0;
        set_wb(1'b1, 4'd5, 32'h55); step();
        set_wb(1'b1, 4'd15, 32'h0); step();

        // Set and clear of R4 in one cycle: set wins
        set_req(1'b1, 4'd1, 4'd2, 4'd4, 1'b1, 32'h0);
        set_wb(1'b1, 4'd4, 32'h444);
        #1;
        check_eq("t5_accept", {31'd0, req_ready}, 32'd1);
        step();
        set_wb(1'b0, 4'd0, 32'h0);
        req_valid = 1'b0;
        step();
        op_ready = 1'b1;
        set_req(1'b1, 4'd1, 4'd4, 4'd0, 1'b0, 32'h0);
        #1;
        check_eq("t5_stall_hold", {31'd0, req_ready}, 32'd0);
        step();
        op_ready = 1'b0;
        check_eq("t5_stall_idle", {31'd0, req_ready}, 32'd0);

        // Async reset in READ clears everything, including sb[4]
        set_req(1'b1, 4'd1, 4'd2, 4'd6, 1'b1, 32'h0);
        #1;
        check_eq("t6_accept", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check_eq("t6_rst_valid", {31'd0, op_valid}, 32'd0);
        check_eq("t6_rst_ready", {31'd0, req_ready}, 32'd0);
        check_eq("t6_rst_op_a", op_a, 32'h0);
        check_eq("t6_rst_has_rd", {31'd0, op_has_rd}, 32'd0);
        step();
        reset = 1'b1;
        check_eq("t6_post_valid", {31'd0, op_valid}, 32'd0);
`ifdef OPFETCH_STALL_CNT_EN
        check_eq("t6_stall_cnt", stall_cnt, 32'd0);
`endif
        set_req(1'b1, 4'd6, 4'd4, 4'd4, 1'b1, 32'h0);
        #1;
        check_eq("t6_first_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        step();
        check_eq("t6_op_b", op_b, 32'h444);
        check_eq("t6_valid", {31'd0, op_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
